dram: RTL and testbench
=======================

// Module: dram
// PURPOSE
// - Cycle-based behavioural model of the off-chip DRAM attached to the SoC memory controller.
// - Row/column-multiplexed, single bank, 32-bit word-addressed storage with byte-lane write enables.
// - Contents live in four byte arrays, mem_byte0..3, that the bench preloads hierarchically.
// - Read data comes back after a fixed CAS latency, flagged by a one-cycle valid pulse.
// PARAMETERS
// ROW_W   11  row address width, latched from a[ROW_W-1:0] on ACT
// COL_W   10  column address width, taken from a[COL_W-1:0] on READ/WRITE
// T_RCD   5   minimum cycles from ACT to the first READ/WRITE
// T_CL    5   cycles from READ acceptance to the valid pulse
// T_RP    5   minimum cycles from PRE to the next ACT
// PORTS
// clk    in   1   clock, all sampling on the rising edge
// rst    in   1   reset, asynchronous, active-high
// cs_n   in   1   chip select, active-low; when high the cycle is a NOP
// ras_n  in   1   row address strobe, active-low
// cas_n  in   1   column address strobe, active-low
// we_n   in   4   byte write enables, active-low; bit i drives mem_byte{i}
// a      in   11  multiplexed row/column address
// d      in   32  write data; byte i is d[8i+7:8i]
// q      out  32  read data
// valid  out  1   one-cycle pulse marking q as new read data
// BEHAVIOUR
// - Storage: mem_byte0..3 each hold 2^(ROW_W+COL_W) entries of 8 bits; word index = {row, col}.
// - Reset affects only control state, never storage: q=0, valid=0, row closed, all timers 0, read pipe empty.
// - Commands are decoded at posedge only when cs_n=0:
//   - ACT:   ras_n=0, cas_n=1, we_n=4'hF
//   - PRE:   ras_n=0, cas_n=1, we_n=4'h0
//   - READ:  ras_n=1, cas_n=0, we_n=4'hF
//   - WRITE: ras_n=1, cas_n=0, we_n!=4'hF
//   - Every other encoding is a NOP.
// - States: IDLE (row closed), ACTIVE (row open), PRECHARGING.
//   - ACT in IDLE with T_RP satisfied: latch row, enter ACTIVE, start the tRCD timer.
//   - PRE in ACTIVE: enter PRECHARGING, then reach IDLE after T_RP cycles.
//   - PRE in IDLE is a NOP.
// - READ/WRITE are legal only in ACTIVE after T_RCD cycles. An illegal command is ignored and a $display error is printed.
// - WRITE takes effect at the accepting edge: for each i with we_n[i]=0, mem_byte{i}[{row,col}] <= d byte i. Other lanes are unchanged.
// - READ: captures the word at {row,col} at acceptance.
//   - T_CL edges later, q takes that word and valid=1 for exactly one cycle.
//   - q then holds its value until the next read completes.
// - Back-to-back READs one cycle apart are pipelined: each returns T_CL later, in order, with no bubbles.
// - WRITE followed by READ of the same word: the READ returns the new data.
// - READ followed by WRITE to the same word: the READ returns the old data.
// - Any command other than PRE issued in PRECHARGING is ignored, with an error message.
// - ACT while ACTIVE is illegal and ignored; the row stays open.
// - Reset mid-read flushes the pipe, so no valid pulse occurs. Storage is preserved.
// - X or Z on control inputs while cs_n=0 is treated as a NOP.
// TESTING
// - Preload mem_byte0..3[0x000123] = 44,33,22,11; ACT a=0x000, wait 5, READ a=0x123 -> valid pulses 5 cycles later with q=0x11223344.
// - WRITE we_n=4'b1010, d=0xAABBCCDD to word {row=0,col=0x123}, then READ -> q=0x11BB33DD.
// - READ issued 2 cycles after ACT -> ignored, no valid pulse, error printed.
// - Three consecutive READs to cols 0,1,2 -> three consecutive valid pulses, in order, each with the correct data.
// - ACT row 5, PRE, ACT row 6 one cycle after PRE -> ignored; ACT 5 cycles after PRE -> accepted, READ returns row-6 data.
// - Assert rst 2 cycles after a READ -> no valid pulse, q=0, and preloaded storage is intact afterwards.

Source files
------------

// File: rtl/dram.sv
// Cycle-based model of a single-bank row/column-multiplexed DRAM with byte-lane writes.
// Read data returns T_CL cycles after READ acceptance with a one-cycle valid pulse; no backpressure.
module dram #(
    parameter int ROW_W = 11,
    parameter int COL_W = 10,
    parameter int T_RCD = 5,
    parameter int T_CL  = 5,
    parameter int T_RP  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic [3:0]       we_n,
    input  logic [ROW_W-1:0] a,
    input  logic [31:0]      d,
    output logic [31:0]      q,
    output logic             valid
);

    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, PRECHARGING} state_t;
    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_READ, CMD_WRITE} cmd_t;

    logic [7:0] mem_byte0 [DEPTH];
    logic [7:0] mem_byte1 [DEPTH];
    logic [7:0] mem_byte2 [DEPTH];
    logic [7:0] mem_byte3 [DEPTH];

    state_t           state, state_nxt;
    cmd_t             cmd;
    logic [ROW_W-1:0] row, row_nxt;
    logic [CW-1:0]    rcd_cnt, rcd_nxt, rp_cnt, rp_nxt;
    logic             rd_acc, wr_acc, illegal, closed;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word;
    logic [T_CL-1:0]  pipe_vld;
    logic [31:0]      pipe_dat [T_CL];

    // Unknown control bits while selected decode to NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (cs_n == 1'b0 && (^{ras_n, cas_n, we_n}) !== 1'bx) begin
            case ({ras_n, cas_n})
                2'b01: begin
                    if (we_n == 4'hF)      cmd = CMD_ACT;
                    else if (we_n == 4'h0) cmd = CMD_PRE;
                end
                2'b10: cmd = (we_n == 4'hF) ? CMD_READ : CMD_WRITE;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        rcd_nxt   = (rcd_cnt != '0) ? rcd_cnt - 1'b1 : rcd_cnt;
        rp_nxt    = (rp_cnt != '0) ? rp_cnt - 1'b1 : rp_cnt;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        illegal   = 1'b0;
        // Precharge completes once its timer has drained; ACT may land on that same edge.
        closed    = (state == IDLE) || (state == PRECHARGING && rp_cnt == '0);
        if (state == PRECHARGING && rp_cnt == '0)
            state_nxt = IDLE;
        case (cmd)
            CMD_ACT: begin
                if (closed) begin
                    state_nxt = ACTIVE;
                    row_nxt   = a;
                    rcd_nxt   = CW'(T_RCD - 1);
                end else begin
                    illegal = 1'b1;
                end
            end
            CMD_PRE: begin
                if (state == ACTIVE) begin
                    state_nxt = PRECHARGING;
                    rp_nxt    = CW'(T_RP - 1);
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (state == ACTIVE && rcd_cnt == '0) begin
                    rd_acc = (cmd == CMD_READ);
                    wr_acc = (cmd == CMD_WRITE);
                end else begin
                    illegal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            rcd_cnt <= '0;
            rp_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            rcd_cnt <= rcd_nxt;
            rp_cnt  <= rp_nxt;
        end
    end

    assign idx     = {row, a[COL_W-1:0]};
    assign rd_word = {mem_byte3[idx], mem_byte2[idx], mem_byte1[idx], mem_byte0[idx]};

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (!we_n[0]) mem_byte0[idx] <= d[7:0];
            if (!we_n[1]) mem_byte1[idx] <= d[15:8];
            if (!we_n[2]) mem_byte2[idx] <= d[23:16];
            if (!we_n[3]) mem_byte3[idx] <= d[31:24];
        end
    end

    always_ff @(posedge clk) begin
        pipe_dat[0] <= rd_word;
        for (int i = 1; i < T_CL; i++)
            pipe_dat[i] <= pipe_dat[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            q        <= '0;
            valid    <= 1'b0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < T_CL; i++)
                pipe_vld[i] <= pipe_vld[i-1];
            valid <= pipe_vld[T_CL-1];
            if (pipe_vld[T_CL-1])
                q <= pipe_dat[T_CL-1];
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && illegal)
            $display("dram error: %s ignored in state %s", cmd.name(), state.name());
    end
`endif

endmodule

// File: tb/tb_dram.sv
// Directed bench for dram: timing, byte lanes, pipelining, precharge and reset behaviour.
module tb_dram;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n, ras_n, cas_n;
    logic [3:0]  we_n;
    logic [10:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        valid;

    int errors = 0;
    int checks = 0;

    dram dut (
        .clk   (clk),
        .rst   (rst),
        .cs_n  (cs_n),
        .ras_n (ras_n),
        .cas_n (cas_n),
        .we_n  (we_n),
        .a     (a),
        .d     (d),
        .q     (q),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one command for exactly one rising edge, then returns to deselect.
    task automatic issue(input logic r, input logic c, input logic [3:0] w,
                         input logic [10:0] addr, input logic [31:0] dat);
        cs_n  = 1'b0;
        ras_n = r;
        cas_n = c;
        we_n  = w;
        a     = addr;
        d     = dat;
        @(posedge clk);
        #1;
        cs_n  = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        we_n  = 4'hF;
    endtask

    task automatic act(input logic [10:0] r);
        issue(1'b0, 1'b1, 4'hF, r, 32'h0);
    endtask

    task automatic pre();
        issue(1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
    endtask

    task automatic rd(input logic [10:0] col);
        issue(1'b1, 1'b0, 4'hF, col, 32'h0);
    endtask

    task automatic wr(input logic [10:0] col, input logic [3:0] w, input logic [31:0] dat);
        issue(1'b1, 1'b0, w, col, dat);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (valid) cnt++;
        end
    endtask

    task automatic preload(input logic [20:0] idx, input logic [31:0] w);
        dut.mem_byte0[idx] = w[7:0];
        dut.mem_byte1[idx] = w[15:8];
        dut.mem_byte2[idx] = w[23:16];
        dut.mem_byte3[idx] = w[31:24];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [20:0] i57;
        rst   = 1'b1;
        cs_n  = 1'b1;
        ras_n = 1'b1;
        cas_n = 1'b1;
        we_n  = 4'hF;
        a     = '0;
        d     = '0;

        preload(21'h000123, 32'h11223344);
        preload(21'h000000, 32'h01020304);
        preload(21'h000001, 32'h05060708);
        preload(21'h000002, 32'h090A0B0C);
        preload(21'h000003, 32'hDEADBEEF);
        i57 = {11'd5, 10'd7};
        preload(i57, 32'h55555555);
        preload({11'd6, 10'd7}, 32'h66666666);
        preload({11'd7, 10'd7}, 32'h77777777);

        tick(2);
        check("reset_q", q, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        rst = 1'b0;
        tick(1);

        // Basic read after tRCD; valid exactly T_CL edges after acceptance.
        act(11'h000);
        tick(4);
        rd(11'h123);
        tick(4);
        check("rd_not_early", {31'h0, valid}, 32'h0);
        tick(1);
        check("rd_valid", {31'h0, valid}, 32'h1);
        check("rd_data", q, 32'h11223344);
        tick(1);
        check("rd_pulse_one", {31'h0, valid}, 32'h0);
        check("rd_q_hold", q, 32'h11223344);

        // Byte-lane write then read of the same word.
        wr(11'h123, 4'b1010, 32'hAABBCCDD);
        rd(11'h123);
        tick(5);
        check("wr_rd_valid", {31'h0, valid}, 32'h1);
        check("wr_rd_data", q, 32'h11BB33DD);

        // Read then write of the same word returns the old data.
        rd(11'h003);
        wr(11'h003, 4'h0, 32'h12345678);
        tick(4);
        check("rd_wr_old", q, 32'hDEADBEEF);
        rd(11'h003);
        tick(5);
        check("rd_wr_new", q, 32'h12345678);

        // Back-to-back pipelined reads.
        rd(11'h000);
        rd(11'h001);
        rd(11'h002);
        tick(2);
        check("pipe_not_early", {31'h0, valid}, 32'h0);
        tick(1);
        check("pipe0_valid", {31'h0, valid}, 32'h1);
        check("pipe0_data", q, 32'h01020304);
        tick(1);
        check("pipe1_valid", {31'h0, valid}, 32'h1);
        check("pipe1_data", q, 32'h05060708);
        tick(1);
        check("pipe2_valid", {31'h0, valid}, 32'h1);
        check("pipe2_data", q, 32'h090A0B0C);
        tick(1);
        check("pipe_end", {31'h0, valid}, 32'h0);

        // tRP: an ACT one cycle after PRE (row 7) must be dropped, the one 5 cycles later (row 6) taken.
        pre();
        tick(4);
        act(11'd5);
        tick(4);
        pre();
        act(11'd7);
        tick(3);
        act(11'd6);
        tick(1);
        rd(11'd7);
        count_valid(7, n);
        check("early_rd_ignored", n, 32'd0);
        rd(11'd7);
        tick(5);
        check("trp_valid", {31'h0, valid}, 32'h1);
        check("trp_row6_data", q, 32'h66666666);

        // ACT while a row is open is ignored and does not restart tRCD.
        act(11'd7);
        rd(11'd7);
        tick(5);
        check("act_active_valid", {31'h0, valid}, 32'h1);
        check("act_active_data", q, 32'h66666666);

        // Reset in the middle of a read flushes it.
        rd(11'd7);
        tick(1);
        rst = 1'b1;
        #1;
        check("rst_q", q, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        tick(2);
        rst = 1'b0;
        count_valid(6, n);
        check("rst_flush", n, 32'd0);
        check("rst_q_after", q, 32'h0);

        // Storage survives reset.
        act(11'h000);
        tick(4);
        rd(11'h000);
        tick(5);
        check("post_rst_valid", {31'h0, valid}, 32'h1);
        check("post_rst_data", q, 32'h01020304);
        check("post_rst_mem", {dut.mem_byte3[i57], dut.mem_byte2[i57],
                               dut.mem_byte1[i57], dut.mem_byte0[i57]}, 32'h55555555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
